// File: rtl/credit_display_mux.sv
// Multiplexed seven-segment credit display: sequential binary-to-BCD
// conversion, optional count-up animation, digit scan with anti-ghost blanking
// and leading-zero suppression.
module credit_display_mux #(
  parameter int unsigned NUM_DIGITS  = 5,
  parameter int unsigned VALUE_W     = 12,
  parameter int unsigned REFRESH_DIV = 4096,
  parameter int unsigned BLANK_CYC   = 64,
  parameter int unsigned STEP_DIV    = 1 << 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  animate,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] enable_sel,
  output logic [6:0]            seg,
  output logic                  busy,
  output logic                  overflow
);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // Work BCD register holds enough digits for any VALUE_W-bit number
  localparam int unsigned BCD_N  = (VALUE_W * 3) / 10 + 1;
  localparam int unsigned BCD_W  = 4 * BCD_N;
  localparam int unsigned DIG_W  = 4 * NUM_DIGITS;
  localparam int unsigned EXT_W  = BCD_W + DIG_W;
  localparam int unsigned RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SCNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned BCNT_W = $clog2(VALUE_W);
  localparam logic [63:0] MAX_SHOWN = pow10(NUM_DIGITS) - 64'd1;

  typedef enum logic [1:0] {IDLE = 2'd0, CONVERT = 2'd1, STEP_WAIT = 2'd2} state_t;

  state_t              state, state_n;
  logic [VALUE_W-1:0]  target, target_n, shown, shown_n, bin, bin_n;
  logic                pending, pending_n, pend_anim, pend_anim_n, anim, anim_n;
  logic [BCD_W-1:0]    bcd, bcd_n, bcd_adj, bcd_step;
  logic [EXT_W-1:0]    bcd_ext;
  logic [BCNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [SCNT_W-1:0]   step_cnt, step_cnt_n;
  logic [DIG_W-1:0]    digits, digits_n;
  logic                overflow_n, busy_n;
  logic                start, start_anim, last_bit, step_done;
  logic [VALUE_W-1:0]  start_val;
  logic [RCNT_W-1:0]   rcnt, rcnt_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic                rcnt_wrap, nz_seen, cur_blank;
  logic [NUM_DIGITS-1:0] lz_mask, enable_n;
  logic [3:0]          cur_digit;
  logic [6:0]          seg_n;

  assign last_bit  = (bit_cnt == BCNT_W'(VALUE_W - 1));
  assign step_done = (step_cnt == SCNT_W'(STEP_DIV - 1));

  // One shift-add-3 step: correct each BCD digit, then shift in the next binary bit
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < int'(BCD_N); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[BCD_W-2:0], bin[VALUE_W-1]};
    bcd_ext  = EXT_W'(bcd_step);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next state; a load (fresh or pending) restarts conversion
  always_comb begin
    state_n    = state;
    start      = 1'b0;
    start_val  = value;
    start_anim = animate;
    case (state)
      IDLE: begin
        if (load) begin
          start = 1'b1;
        end else if (pending) begin
          start      = 1'b1;
          start_val  = target;
          start_anim = pend_anim;
        end
      end
      CONVERT: begin
        if (last_bit) state_n = (anim && (shown < target)) ? STEP_WAIT : IDLE;
      end
      STEP_WAIT: begin
        // A load arriving now becomes pending and is taken next cycle
        if (pending && !load) begin
          start      = 1'b1;
          start_val  = target;
          start_anim = pend_anim;
        end else if (!pending && !load && step_done) begin
          state_n = CONVERT;
        end
      end
      default: state_n = IDLE;
    endcase
    if (start) state_n = CONVERT;
  end

  // Datapath next values and registered status outputs
  always_comb begin
    target_n    = target;
    shown_n     = shown;
    pending_n   = pending;
    pend_anim_n = pend_anim;
    anim_n      = anim;
    bin_n       = bin;
    bcd_n       = bcd;
    bit_cnt_n   = bit_cnt;
    step_cnt_n  = step_cnt;
    digits_n    = digits;
    overflow_n  = overflow;
    if (start) begin
      target_n  = start_val;
      pending_n = 1'b0;
      if (start_anim && (start_val > shown)) begin
        shown_n = shown + VALUE_W'(1);
        anim_n  = 1'b1;
      end else begin
        shown_n = start_val;
        anim_n  = 1'b0;
      end
      bin_n      = shown_n;
      bcd_n      = '0;
      bit_cnt_n  = '0;
      step_cnt_n = '0;
    end else begin
      case (state)
        CONVERT: begin
          bin_n     = bin << 1;
          bcd_n     = bcd_step;
          bit_cnt_n = bit_cnt + BCNT_W'(1);
          if (last_bit) begin
            if (64'(shown) > MAX_SHOWN) begin
              digits_n   = {NUM_DIGITS{4'h9}};
              overflow_n = 1'b1;
            end else begin
              digits_n   = bcd_ext[DIG_W-1:0];
              overflow_n = 1'b0;
            end
            if (state_n == IDLE) anim_n = 1'b0;
            step_cnt_n = '0;
          end
        end
        STEP_WAIT: begin
          if (state_n == CONVERT) begin
            shown_n    = shown + VALUE_W'(1);
            bin_n      = shown + VALUE_W'(1);
            bcd_n      = '0;
            bit_cnt_n  = '0;
            step_cnt_n = '0;
          end else if (!pending && !load) begin
            step_cnt_n = step_cnt + SCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    if (load && (state != IDLE)) begin
      target_n    = value;
      pending_n   = 1'b1;
      pend_anim_n = animate;
    end
    busy_n = (state_n != IDLE) || pending_n;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target    <= '0;
      shown     <= '0;
      pending   <= 1'b0;
      pend_anim <= 1'b0;
      anim      <= 1'b0;
      bin       <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      step_cnt  <= '0;
      digits    <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      target    <= target_n;
      shown     <= shown_n;
      pending   <= pending_n;
      pend_anim <= pend_anim_n;
      anim      <= anim_n;
      bin       <= bin_n;
      bcd       <= bcd_n;
      bit_cnt   <= bit_cnt_n;
      step_cnt  <= step_cnt_n;
      digits    <= digits_n;
      overflow  <= overflow_n;
      busy      <= busy_n;
    end
  end

  // Leading-zero mask from committed digits; digit 0 always shown
  always_comb begin
    lz_mask = '0;
    nz_seen = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      nz_seen    = nz_seen | (digits[4*i +: 4] != 4'd0);
      lz_mask[i] = blank_lz & ~nz_seen;
    end
  end

  // Scan counters and the enable/segment pattern for the upcoming cycle
  always_comb begin
    rcnt_wrap = (rcnt == RCNT_W'(REFRESH_DIV - 1));
    rcnt_n    = rcnt_wrap ? '0 : rcnt + RCNT_W'(1);
    idx_n     = idx;
    if (rcnt_wrap) idx_n = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    enable_n  = '1;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_n == IDX_W'(i)) begin
        if (rcnt_n >= RCNT_W'(BLANK_CYC)) enable_n[i] = 1'b0;
        cur_digit = digits[4*i +: 4];
        cur_blank = lz_mask[i];
      end
    end
    seg_n = cur_blank ? 7'h7F : seg_code(cur_digit);
  end

  // Scan registers; seg and enables update on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rcnt       <= '0;
      idx        <= '0;
      enable_sel <= '1;
      seg        <= 7'h7F;
    end else begin
      rcnt       <= rcnt_n;
      idx        <= idx_n;
      enable_sel <= enable_n;
      seg        <= seg_n;
    end
  end

endmodule

// File: tb/tb_credit_display_mux.sv
// Bench for credit_display_mux: two instances (5 and 3 digits) share stimulus;
// expected display comes from decimal arithmetic on the loaded value.
module tb_credit_display_mux;

  localparam int VW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [VW-1:0] value;
  logic          load, animate, blank_lz;
  logic [4:0]    en5;
  logic [2:0]    en3;
  logic [6:0]    seg5, seg3;
  logic          busy5, busy3, ovf5, ovf3;

  int ntests = 0;
  int nfail  = 0;
  int model_shown;
  logic [6:0] got5 [5];
  logic [6:0] got3 [3];

  credit_display_mux #(.NUM_DIGITS(5), .VALUE_W(VW), .REFRESH_DIV(8), .BLANK_CYC(1), .STEP_DIV(32)) dut5 (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load), .animate(animate),
    .blank_lz(blank_lz), .enable_sel(en5), .seg(seg5), .busy(busy5), .overflow(ovf5));

  credit_display_mux #(.NUM_DIGITS(3), .VALUE_W(VW), .REFRESH_DIV(8), .BLANK_CYC(1), .STEP_DIV(32)) dut3 (
    .clk(clk), .reset_n(reset_n), .value(value), .load(load), .animate(animate),
    .blank_lz(blank_lz), .enable_sel(en3), .seg(seg3), .busy(busy3), .overflow(ovf3));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    logic [6:0] t [10];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  // Expected segments for digit i of an nd-digit display showing v
  function automatic logic [6:0] exp_seg(input int v, input int i, input int nd, input bit lz);
    int p;
    int lim;
    p = 1;
    lim = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    for (int k = 0; k < nd; k++) lim = lim * 10;
    if (v > lim - 1) return enc(9);
    if (lz && (i > 0) && (v / p == 0)) return 7'h7F;
    return enc((v / p) % 10);
  endfunction

  task automatic do_load(input int v, input bit anim);
    value   = VW'(v);
    animate = anim;
    load    = 1'b1;
    tick();
    load    = 1'b0;
    animate = 1'b0;
  endtask

  task automatic wait_busy(input int limit, output int n);
    n = 0;
    while (busy5 === 1'b1 && n < limit) begin
      n++;
      tick();
    end
  endtask

  // Observe one full scan frame, capturing the segments shown per digit
  task automatic scan(input string tag);
    logic bad5, bad3;
    logic [4:0] m5;
    logic [2:0] m3;
    bad5 = 1'b0;
    bad3 = 1'b0;
    for (int i = 0; i < 5; i++) got5[i] = 7'bx;
    for (int i = 0; i < 3; i++) got3[i] = 7'bx;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (en5 !== 5'h1F && !$onehot(~en5)) bad5 = 1'b1;
      if (en3 !== 3'h7 && !$onehot(~en3)) bad3 = 1'b1;
      for (int i = 0; i < 5; i++) begin
        m5 = ~(5'd1 << i);
        if (en5 === m5) got5[i] = seg5;
      end
      for (int i = 0; i < 3; i++) begin
        m3 = ~(3'd1 << i);
        if (en3 === m3) got3[i] = seg3;
      end
    end
    check({tag, "_en5_legal"}, 32'(bad5), 32'd0);
    check({tag, "_en3_legal"}, 32'(bad3), 32'd0);
  endtask

  task automatic check_display(input string tag, input int v);
    scan(tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_d5_%0d", tag, i), 32'(got5[i]), 32'(exp_seg(v, i, 5, blank_lz)));
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_d3_%0d", tag, i), 32'(got3[i]), 32'(exp_seg(v, i, 3, blank_lz)));
    check({tag, "_ovf5"}, 32'(ovf5), 32'(v > 99999));
    check({tag, "_ovf3"}, 32'(ovf3), 32'(v > 999));
  endtask

  initial begin
    int n;
    int v;
    bit a;
    logic [4:0] exp_en;

    reset_n  = 1'b0;
    value    = '0;
    load     = 1'b0;
    animate  = 1'b0;
    blank_lz = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset state and first two scan slots
    check("rst_en", 32'(en5), 32'h1F);
    check("rst_seg", 32'(seg5), 32'h7F);
    check("rst_busy", 32'(busy5), 32'd0);
    check("rst_ovf", 32'(ovf5), 32'd0);
    for (int c = 1; c < 16; c++) begin
      tick();
      exp_en = (c % 8 == 0) ? 5'h1F : ~(5'd1 << ((c / 8) % 5));
      check($sformatf("scan_en_c%0d", c), 32'(en5), 32'(exp_en));
      if (c == 1 || c == 9) check($sformatf("scan_seg_c%0d", c), 32'(seg5), 32'h40);
    end
    check_display("rst_disp", 0);

    // Plain load: busy for exactly VALUE_W cycles, then 1234 on the display
    do_load(1234, 1'b0);
    wait_busy(200, n);
    check("busy_1234", 32'(n), 32'd12);
    check_display("d1234", 1234);
    blank_lz = 1'b1;
    check_display("d1234_lz", 1234);
    blank_lz = 1'b0;

    // Reset mid-conversion clears everything asynchronously
    do_load(1234, 1'b0);
    repeat (5) tick();
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(en5), 32'h1F);
    check("mid_rst_seg", 32'(seg5), 32'h7F);
    check("mid_rst_busy", 32'(busy5), 32'd0);
    check("mid_rst_ovf3", 32'(ovf3), 32'd0);
    tick();
    reset_n = 1'b1;
    check_display("post_rst", 0);

    // Animated count 7 -> 10, commits spaced STEP_DIV+VALUE_W cycles
    do_load(7, 1'b0);
    wait_busy(200, n);
    blank_lz = 1'b1;
    do_load(10, 1'b1);
    repeat (13) tick();
    scan("anim8");
    check("anim8_d0", 32'(got5[0]), 32'(enc(8)));
    check("anim8_d1", 32'(got5[1]), 32'h7F);
    repeat (4) tick();
    scan("anim9");
    check("anim9_d0", 32'(got5[0]), 32'(enc(9)));
    check("anim9_d1", 32'(got5[1]), 32'h7F);
    repeat (2) tick();
    check("anim_busy_hi", 32'(busy5), 32'd1);
    tick();
    check("anim_busy_lo", 32'(busy5), 32'd0);
    check_display("anim10", 10);
    blank_lz = 1'b0;

    // Animation to 100 overridden by a plain load of 5 during the step to 3
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    do_load(100, 1'b1);
    repeat (91) tick();
    check("ovr_busy_mid", 32'(busy5), 32'd1);
    do_load(5, 1'b0);
    wait_busy(500, n);
    check("ovr_busy_bound", 32'((n >= 9) && (n <= 30)), 32'd1);
    check_display("ovr5", 5);
    repeat (100) tick();
    check("ovr_idle", 32'(busy5), 32'd0);
    check_display("ovr5_late", 5);

    // Load held high: latest value wins
    load = 1'b1;
    value = VW'(100);
    tick();
    value = VW'(200);
    tick();
    value = VW'(300);
    tick();
    load = 1'b0;
    wait_busy(200, n);
    check("held_busy_bound", 32'((n >= 10) && (n <= 40)), 32'd1);
    check_display("held300", 300);

    // Overflow boundaries on the 3-digit instance
    do_load(4095, 1'b0);
    wait_busy(200, n);
    check_display("ovf4095", 4095);
    do_load(999, 1'b0);
    wait_busy(200, n);
    check_display("ovf999", 999);
    do_load(1000, 1'b0);
    wait_busy(200, n);
    check_display("ovf1000", 1000);
    do_load(12, 1'b0);
    wait_busy(200, n);
    check_display("ovf12", 12);
    model_shown = 12;

    // Random loads, some animated by small steps
    for (int it = 0; it < 12; it++) begin
      a = 1'($urandom_range(0, 1));
      if (a) begin
        v = model_shown + int'($urandom_range(0, 3));
        if (v > 4095) v = 4095;
      end else begin
        v = int'($urandom_range(0, 4095));
      end
      blank_lz = 1'($urandom_range(0, 1));
      do_load(v, a);
      wait_busy(1000, n);
      check($sformatf("rnd%0d_busy", it), 32'(n),
            32'((a && v > model_shown) ? 12 + (v - model_shown - 1) * 44 : 12));
      model_shown = v;
      check_display($sformatf("rnd%0d", it), v);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/credit_display_mux.md
# credit_display_mux

Parametrised multiplexed seven-segment credit display for the slot machine FPGA. It accepts a binary credit value from the SPI register path and converts it to BCD with a sequential shift-add-3 engine. It drives NUM_DIGITS common-enable digits with anti-ghosting blanking, leading-zero suppression and an optional count-up animation. It supersedes the fixed 5-digit, pre-split-nibble credit display and runs on the PLL pixel clock.

## Interface
- NUM_DIGITS, 5, number of digits driven (1..8)
- VALUE_W, 12, width of binary input value (4..24)
- REFRESH_DIV, 4096, clock cycles each digit slot is held
- BLANK_CYC, 64, cycles at start of each slot with all enables off (< REFRESH_DIV)
- STEP_DIV, 2^20, cycles between +1 animation steps (> VALUE_W+2)
- clk  in  1  PLL clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- value  in  VALUE_W  unsigned binary credit value
- load  in  1  one-cycle strobe; captures value
- animate  in  1  sampled with load; 1 = count up to value
- blank_lz  in  1  1 = suppress leading zeros (level, live)
- enable_sel  out  NUM_DIGITS  active-low digit enables, one-hot-low or all-high
- seg  out  7  active-low segments {g,f,e,d,c,b,a}
- busy  out  1  conversion or animation in progress
- overflow  out  1  shown value exceeds 10^NUM_DIGITS-1

## Operation
- Registers: target (VALUE_W), shown (VALUE_W), digits (4*NUM_DIGITS BCD), pending flag, refresh counter, digit index, step counter.
- FSM: IDLE, CONVERT, STEP_WAIT.
- IDLE + load: target<=value. If animate=0 or value<=shown, then shown<=value and go to CONVERT. Otherwise shown<=shown+1, go to CONVERT, and set the animation flag.
- CONVERT: shift-add-3 over shown, one bit per cycle, VALUE_W cycles. Work registers are separate from digits. On the final cycle, digits commits atomically. If shown>10^NUM_DIGITS-1, digits commits to all 9s and overflow is set; otherwise overflow is cleared. Exit: animation flag and shown<target -> STEP_WAIT; else -> IDLE and the animation flag clears.
- STEP_WAIT: the step counter counts STEP_DIV cycles, then shown<=shown+1 and go to CONVERT.
- load outside IDLE: target<=value and pending<=1, with animate latched. The latest load wins. On the next entry to IDLE, pending is serviced the same cycle as a fresh load, and pending clears. A non-animated load overrides a running animation at the next IDLE/STEP_WAIT boundary. In STEP_WAIT, a pending load is taken immediately.
- busy=1 in CONVERT and STEP_WAIT, and while pending=1.
- Scan: the refresh counter wraps at REFRESH_DIV-1. On wrap, the digit index advances, wrapping NUM_DIGITS-1 -> 0. Index 0 is the least significant digit and maps to enable_sel[0].
- During the first BLANK_CYC cycles of a slot, enable_sel is all ones. Afterwards, bit [index] is 0 and the others are 1.
- seg encoding, digits 0-9: 40,79,24,30,19,12,02,78,00,10 (hex). Codes A-F cannot occur.
- Leading-zero blank: with blank_lz=1, a digit above the highest nonzero digit outputs seg=7F. Digit 0 is never blanked. Blanking uses committed digits only.
- Arithmetic: shown increments never exceed target; there is no wrap at 2^VALUE_W.

## Timing
- Reset (async assert, sync-released use): enable_sel all ones, seg=7F, busy=0, overflow=0, shown=0, target=0, digits=0, index=0, all counters=0, state IDLE.
- After reset the display shows "0" at digit 0; with blank_lz=0 it shows zeros on all digits.
- seg and enable_sel are registered and change on the same edge; seg is valid for the whole enabled window.
- Latency: load at edge k -> busy=1 from edge k -> digits commit at edge k+VALUE_W. busy falls at edge k+VALUE_W when nothing is pending and there is no animation.
- An animated step adds STEP_DIV+VALUE_W cycles per count.
- Reset asserted mid-conversion or mid-animation returns all outputs to reset values immediately; no partial digits survive.
- load held high for multiple cycles is treated as repeated loads; behaviour stays consistent under the latest-wins rule.

## Test plan
Bench parameters: NUM_DIGITS=5, VALUE_W=12, REFRESH_DIV=8, BLANK_CYC=1, STEP_DIV=32.
- Reset release, no load -> enable_sel=11111 at cycle 0, then pattern 11110 in cycles 1-7 of slot 0. blank_lz=0: seg=40 on all five digits. busy=0.
- load value=1234, animate=0 -> busy high for exactly 12 cycles. Scan over one full frame gives digit0..4 seg = 19,30,24,79,40. With blank_lz=1, digit 4 shows 7F.
- shown=7, load value=10, animate=1 -> shown steps 8,9,10 with commits spaced 44 cycles apart. busy falls after the commit for 10. digit1 goes from 7F to 79 when blank_lz=1.
- Animation to 100 from 0, with a non-animated load of 5 issued during the step to 3 -> final digits=00005, busy=0, shown never exceeds 5 after the override.
- NUM_DIGITS=3, load 4095 -> overflow=1, digits 999 (seg 10,10,10). Then load 12 -> overflow=0.
- reset_n pulsed low in the middle of CONVERT for 1234 -> outputs at reset values asynchronously. After release, the display shows 0 and no stale digits.
